// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - serial carry-save multi-operand accumulator with single-step resolve
// Operands fold into a sum/carry pair one 3:2 compression at a time; one CPA produces the result.
module csa_accum_ctrl #(
  parameter int N     = 64,
  parameter int M_MAX = 16,
  parameter int CW    = $clog2(M_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          cin,
  input  logic          abort,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [N-1:0]  op_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_sum,
  output logic          res_cout,
  output logic          busy,
  output logic          err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [CW-1:0] M_MAX_C = CW'(M_MAX);

  logic [1:0]    state;
  logic [N-1:0]  s;
  logic [N-1:0]  cv;
  logic [CW-1:0] rem;
  logic          cin_l;
  logic [N-1:0]  maj;
  logic [N:0]    cpa;

  assign op_ready  = (state == LOAD);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign maj = (s & cv) | (s & op_data) | (cv & op_data);
  assign cpa = {1'b0, s} + {1'b0, cv} + {{N{1'b0}}, cin_l};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s        <= '0;
      cv       <= '0;
      rem      <= '0;
      cin_l    <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort) begin
        // In IDLE abort also masks start for that cycle.
        if (state != IDLE) begin
          state <= IDLE;
          s     <= '0;
          cv    <= '0;
          rem   <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (count > M_MAX_C) begin
                err <= 1'b1;
              end else begin
                cin_l <= cin;
                s     <= '0;
                cv    <= '0;
                rem   <= count;
                state <= (count == '0) ? RESOLVE : LOAD;
              end
            end
          end
          LOAD: begin
            if (op_valid) begin
              s   <= s ^ cv ^ op_data;
              // The carry out of the MSB is dropped; the result stays correct mod 2^N.
              cv  <= maj << 1;
              rem <= rem - CW'(1);
              if (rem == CW'(1)) state <= RESOLVE;
            end
          end
          RESOLVE: begin
            {res_cout, res_sum} <= cpa;
            state               <= DONE;
          end
          DONE: begin
            if (res_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - self-checking bench for csa_accum_ctrl
// Directed vector table, hand-written corner sequences and randomized runs against a model.
module tb_csa_accum_ctrl;

  localparam int N  = 8;
  localparam int M  = 6;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] count;
  logic          cin;
  logic          abort;
  logic          op_valid;
  logic          op_ready;
  logic [N-1:0]  op_data;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_sum;
  logic          res_cout;
  logic          busy;
  logic          err;

  csa_accum_ctrl #(.N(N), .M_MAX(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count), .cin(cin),
    .abort(abort), .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cnt;
    logic        c;
    logic [47:0] ops;
    logic [7:0]  esum;
    logic        ecout;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sum is plain modular arithmetic; carry-out follows the compression rule on S/Cv.
  function automatic void model(input int cnt, input logic c, input logic [47:0] ops,
                                output logic [7:0] esum, output logic ecout);
    int unsigned total;
    logic [7:0]  s, cv, x, m;
    logic [8:0]  f;
    total = 32'(c);
    s = '0;
    cv = '0;
    for (int i = 0; i < cnt; i++) begin
      x = ops[i*8 +: 8];
      total += 32'(x);
      m = (s & cv) | (s & x) | (cv & x);
      s = s ^ cv ^ x;
      cv = m << 1;
    end
    esum = total[7:0];
    f = {1'b0, s} + {1'b0, cv} + 9'(c);
    ecout = f[8];
  endfunction

  task automatic run_job(input string tag, input int cnt, input logic c, input logic [47:0] ops,
                         input int gap_mode, input int rdly,
                         input logic [7:0] esum, input logic ecout);
    int   idx;
    int   budget;
    int   phase;
    logic drive_v;
    logic accepted;
    @(negedge clk);
    start = 1'b1;
    count = cnt[CW-1:0];
    cin   = c;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    budget = 0;
    phase = 0;
    while (idx < cnt && budget < 200) begin
      case (gap_mode)
        0:       drive_v = 1'b1;
        1:       drive_v = (phase % 2 == 0);
        default: drive_v = 1'($urandom_range(0, 1));
      endcase
      phase++;
      op_valid = drive_v;
      op_data  = drive_v ? ops[idx*8 +: 8] : 8'($urandom);
      accepted = drive_v && op_ready;
      @(negedge clk);
      if (accepted) idx++;
      budget++;
    end
    op_valid = 1'b0;
    chk({tag, "_ops_accepted"}, 64'(idx), 64'(cnt));
    chk({tag, "_resolve_no_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_resolve_no_ready"}, 64'(op_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_res_sum"}, 64'(res_sum), 64'(esum));
    chk({tag, "_res_cout"}, 64'(res_cout), 64'(ecout));
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      chk({tag, "_hold_sum"}, 64'(res_sum), 64'(esum));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_valid_clear"}, 64'(res_valid), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  es;
    logic        ec;
    logic [47:0] rops;
    int          rcnt;
    logic        rc;

    vecs[0] = '{5, 1'b1, 48'h00_05_04_03_02_01, 8'h10, 1'b0};
    vecs[1] = '{3, 1'b0, 48'h00_00_00_FF_FF_FF, 8'hFD, 1'b0};
    vecs[2] = '{0, 1'b1, 48'h0,                 8'h01, 1'b0};
    vecs[3] = '{1, 1'b0, 48'h00_00_00_00_00_80, 8'h80, 1'b0};
    vecs[4] = '{2, 1'b1, 48'h00_00_00_00_01_FF, 8'h01, 1'b1};
    vecs[5] = '{6, 1'b0, 48'h60_50_40_30_20_10, 8'h50, 1'b1};

    rst_n = 1'b0; start = 1'b0; count = '0; cin = 1'b0; abort = 1'b0;
    op_valid = 1'b0; op_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_sum", 64'(res_sum), 64'd0);
    chk("rst_res_cout", 64'(res_cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_job($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].c, vecs[i].ops, 0, 0,
              vecs[i].esum, vecs[i].ecout);

    run_job("backpressure", 3, 1'b0, 48'h00_00_00_FF_FF_FF, 1, 4, 8'hFD, 1'b0);

    @(negedge clk);
    start = 1'b1; count = 3'd7; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("err_single", 64'(err), 64'd0);
    chk("err_busy_after", 64'(busy), 64'd0);

    start = 1'b1; abort = 1'b1; count = 3'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_idle_start_masked", 64'(busy), 64'd0);

    start = 1'b1; count = 3'd4; cin = 1'b1;
    @(negedge clk);
    start = 1'b0; op_valid = 1'b1; op_data = 8'h55;
    @(negedge clk);
    op_data = 8'h66;
    @(negedge clk);
    abort = 1'b1; op_data = 8'h77;
    @(negedge clk);
    abort = 1'b0; op_valid = 1'b0;
    chk("abort_load_busy", 64'(busy), 64'd0);
    chk("abort_load_ready", 64'(op_ready), 64'd0);
    run_job("after_abort", 2, 1'b0, 48'h00_00_00_00_09_07, 0, 0, 8'h10, 1'b0);

    start = 1'b1; count = 3'd1; cin = 1'b0;
    @(negedge clk);
    start = 1'b0; op_valid = 1'b1; op_data = 8'h11;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("abort_done_valid_before", 64'(res_valid), 64'd1);
    abort = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; res_ready = 1'b0;
    chk("abort_done_valid", 64'(res_valid), 64'd0);
    chk("abort_done_busy", 64'(busy), 64'd0);

    start = 1'b1; count = 3'd3; cin = 1'b0;
    @(negedge clk);
    start = 1'b0; op_valid = 1'b1; op_data = 8'h21;
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_op_ready", 64'(op_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_res_sum", 64'(res_sum), 64'd0);
    chk("arst_res_cout", 64'(res_cout), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job("after_reset", 3, 1'b0, 48'h00_00_00_03_02_01, 0, 0, 8'h06, 1'b0);

    for (int r = 0; r < 40; r++) begin
      rcnt = $urandom_range(0, M);
      rc   = 1'($urandom_range(0, 1));
      rops = {16'($urandom), 32'($urandom)};
      model(rcnt, rc, rops, es, ec);
      run_job($sformatf("rand%0d", r), rcnt, rc, rops, 2, $urandom_range(0, 3), es, ec);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
